msix_irq_scheduler: RTL and testbench

MSIX_IRQ_SCHEDULER -- requirements
Module: msix_irq_scheduler

---
 rtl/pcileech_msix_pkg.sv | 27 ++
 rtl/msix_rr_arbiter.sv | 50 +++++
 rtl/msix_irq_scheduler.sv | 174 +++++++++++++++++
 tb/tb_msix_irq_scheduler.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_msix_pkg.sv
// -----------------------------------------------------------------------------
// pcileech_msix_pkg
// Shared definitions for the MSI-X interrupt scheduler:
//   msix_state_e        - scheduler FSM states (IDLE, ISSUE, WAIT_ACK)
//   MSIX_VECTOR_W       - width of the vector number handed to the PCIe core
//   DEFAULT_NUM_VECTORS - default number of scheduled vectors
//   DEFAULT_ACK_TIMEOUT - default acknowledge timeout in cycles
//   msix_idx_width()    - index width for a given vector count (minimum 1)
// -----------------------------------------------------------------------------
package pcileech_msix_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } msix_state_e;

    localparam int MSIX_VECTOR_W       = 11;
    localparam int DEFAULT_NUM_VECTORS = 8;
    localparam int DEFAULT_ACK_TIMEOUT = 255;

    // A single-vector build still needs a 1-bit index signal.
    function automatic int msix_idx_width(input int num_vectors);
        return (num_vectors > 1) ? $clog2(num_vectors) : 1;
    endfunction

endpackage

// File: rtl/msix_rr_arbiter.sv
// -----------------------------------------------------------------------------
// msix_rr_arbiter
// Combinational round-robin selector. Picks the lowest eligible index strictly
// above last_grant; if none exists it wraps and picks the lowest eligible index
// overall (which may be last_grant itself when it is the only candidate).
// Ports:
//   eligible    [NUM_VECTORS-1:0] in  - candidate vectors
//   last_grant  [IDX_W-1:0]       in  - most recently completed grant
//   grant       [IDX_W-1:0]       out - selected index (0 when none)
//   grant_valid                   out - high when any vector is eligible
// -----------------------------------------------------------------------------
module msix_rr_arbiter
    import pcileech_msix_pkg::*;
#(
    parameter int NUM_VECTORS = DEFAULT_NUM_VECTORS,
    parameter int IDX_W       = msix_idx_width(NUM_VECTORS)
) (
    input  logic [NUM_VECTORS-1:0] eligible,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [IDX_W-1:0]       grant,
    output logic                   grant_valid
);

    logic [IDX_W-1:0] hi_grant;
    logic             hi_valid;
    logic [IDX_W-1:0] lo_grant;
    logic             lo_valid;

    // Scan downward so the lowest qualifying index is written last and wins.
    always_comb begin
        hi_grant = '0;
        hi_valid = 1'b0;
        lo_grant = '0;
        lo_valid = 1'b0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_grant = IDX_W'(i);
                lo_valid = 1'b1;
                if (IDX_W'(i) > last_grant) begin
                    hi_grant = IDX_W'(i);
                    hi_valid = 1'b1;
                end
            end
        end
    end

    assign grant       = hi_valid ? hi_grant : lo_grant;
    assign grant_valid = lo_valid;

endmodule

// File: rtl/msix_irq_scheduler.sv
// -----------------------------------------------------------------------------
// msix_irq_scheduler
// Collects per-vector interrupt events into a Pending Bit Array and issues them
// one at a time to the PCIe core as MSI-X requests, round-robin across vectors.
// A request stays pending until the core acknowledges it.
//
// Build option: define MSIX_ACK_TIMEOUT_EN to enable the acknowledge timeout.
// With it, a missing ack for ACK_TIMEOUT WAIT_ACK cycles pulses timeout_err and
// the vector is retried; without it the scheduler waits for the ack forever.
//
// Ports:
//   clk                in  - clock, rising edge
//   reset              in  - synchronous active-high reset
//   irq_req            in  - per-vector event pulses
//   vec_mask           in  - per-vector mask bits from the MSI-X table
//   msix_enable        in  - MSI-X Enable capability bit
//   func_mask          in  - Function Mask capability bit
//   msix_interrupt     out - one-cycle request pulse to the core
//   msix_vector        out - vector number, held until the next issue
//   msix_interrupt_ack in  - core acknowledge of the outstanding request
//   pending            out - Pending Bit Array
//   busy               out - high whenever the FSM is not IDLE
//   timeout_err        out - one-cycle pulse on acknowledge timeout
//
// Handshake: a request is offered by a single-cycle msix_interrupt pulse; the
// core completes it with msix_interrupt_ack, which is only honoured while the
// FSM is in WAIT_ACK (acks in IDLE or ISSUE are dropped).
// -----------------------------------------------------------------------------
module msix_irq_scheduler
    import pcileech_msix_pkg::*;
#(
    parameter int NUM_VECTORS = DEFAULT_NUM_VECTORS,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_VECTORS-1:0]   irq_req,
    input  logic [NUM_VECTORS-1:0]   vec_mask,
    input  logic                     msix_enable,
    input  logic                     func_mask,
    output logic                     msix_interrupt,
    output logic [MSIX_VECTOR_W-1:0] msix_vector,
    input  logic                     msix_interrupt_ack,
    output logic [NUM_VECTORS-1:0]   pending,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IDX_W = msix_idx_width(NUM_VECTORS);

    if (NUM_VECTORS < 1 || NUM_VECTORS > 32 || ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_param_check
        $error("msix_irq_scheduler: NUM_VECTORS or ACK_TIMEOUT out of range");
    end

    msix_state_e              state;
    logic [NUM_VECTORS-1:0]   pending_q;
    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         grant_q;
    logic                     interrupt_q;
    logic [MSIX_VECTOR_W-1:0] vector_q;
    logic                     busy_q;

    logic [NUM_VECTORS-1:0]   eligible;
    logic [IDX_W-1:0]         arb_grant;
    logic                     arb_valid;
    logic                     ack_accept;
    logic [NUM_VECTORS-1:0]   ack_clear;

    assign eligible = (msix_enable && !func_mask) ? (pending_q & ~vec_mask) : '0;

    msix_rr_arbiter #(
        .NUM_VECTORS (NUM_VECTORS),
        .IDX_W       (IDX_W)
    ) u_arb (
        .eligible    (eligible),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    assign ack_accept = (state == ST_WAIT_ACK) && msix_interrupt_ack;
    assign ack_clear  = ack_accept ? (NUM_VECTORS'(1) << grant_q) : '0;

    // New events are OR-ed in after the clear, so an event on the granted
    // vector in the ack cycle leaves it pending and it gets rescheduled.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~ack_clear) | irq_req;
        end
    end

`ifdef MSIX_ACK_TIMEOUT_EN
    logic [15:0] ack_cnt;
    logic        timeout_q;
    logic        ack_expired;

    // The counter reaches ACK_TIMEOUT on the edge that ends the last
    // allowed WAIT_ACK cycle; an ack on that same cycle still wins.
    assign ack_expired = (ack_cnt == 16'(ACK_TIMEOUT - 1));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            last_grant  <= IDX_W'(NUM_VECTORS - 1);
            grant_q     <= '0;
            interrupt_q <= 1'b0;
            vector_q    <= '0;
            busy_q      <= 1'b0;
`ifdef MSIX_ACK_TIMEOUT_EN
            ack_cnt     <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            interrupt_q <= 1'b0;
`ifdef MSIX_ACK_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state       <= ST_ISSUE;
                        grant_q     <= arb_grant;
                        interrupt_q <= 1'b1;
                        vector_q    <= MSIX_VECTOR_W'(arb_grant);
                        busy_q      <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_ACK;
`ifdef MSIX_ACK_TIMEOUT_EN
                    ack_cnt <= '0;
`endif
                end
                ST_WAIT_ACK: begin
                    // Mask or enable changes are ignored here: the message
                    // has already gone out and only the ack completes it.
                    if (msix_interrupt_ack) begin
                        state      <= ST_IDLE;
                        last_grant <= grant_q;
                        busy_q     <= 1'b0;
                    end
`ifdef MSIX_ACK_TIMEOUT_EN
                    else begin
                        ack_cnt <= ack_cnt + 16'd1;
                        if (ack_expired) begin
                            state     <= ST_IDLE;
                            busy_q    <= 1'b0;
                            timeout_q <= 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign msix_interrupt = interrupt_q;
    assign msix_vector    = vector_q;
    assign pending        = pending_q;
    assign busy           = busy_q;
`ifdef MSIX_ACK_TIMEOUT_EN
    assign timeout_err    = timeout_q;
`else
    assign timeout_err    = 1'b0;
`endif

endmodule

// File: tb/tb_msix_irq_scheduler.sv
// -----------------------------------------------------------------------------
// tb_msix_irq_scheduler
// Directed scenarios followed by randomized traffic. A timeline reference model
// predicts, at every clock edge, which vector is requested and on which cycle,
// the pending array, busy and timeout pulses; a negedge monitor compares.
// -----------------------------------------------------------------------------
module tb_msix_irq_scheduler;

    localparam int NV = 8;
    localparam int TO = 4;
`ifdef MSIX_ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [NV-1:0] irq_req;
    logic [NV-1:0] vec_mask;
    logic          msix_enable;
    logic          func_mask;
    logic          ack;
    logic          msix_interrupt;
    logic [10:0]   msix_vector;
    logic [NV-1:0] pending;
    logic          busy;
    logic          timeout_err;

    msix_irq_scheduler #(
        .NUM_VECTORS (NV),
        .ACK_TIMEOUT (TO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .irq_req            (irq_req),
        .vec_mask           (vec_mask),
        .msix_enable        (msix_enable),
        .func_mask          (func_mask),
        .msix_interrupt     (msix_interrupt),
        .msix_vector        (msix_vector),
        .msix_interrupt_ack (ack),
        .pending            (pending),
        .busy               (busy),
        .timeout_err        (timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (timeline based) ----------------
    // cyc = index of the current clock interval. A request decided at the edge
    // ending interval c is on the wire in c+1; the ack window opens at c+2.
    int            cyc = 0;
    bit            m_started = 1'b0;
    logic [NV-1:0] m_pending;
    int            m_out;         // outstanding vector, -1 when none
    int            m_wait_start;
    int            m_last;
    logic [10:0]   m_vec;
    logic          m_terr;
    logic [NV-1:0] m_elig;
    int            m_acked;
    bit            m_found;
    int            exp_vec_q[$];
    int            exp_cyc_q[$];

    always @(posedge clk) begin
        if (reset) begin
            m_started = 1'b1;
            m_pending = '0;
            m_out     = -1;
            m_last    = NV - 1;
            m_vec     = '0;
            m_terr    = 1'b0;
            exp_vec_q.delete();
            exp_cyc_q.delete();
        end else if (m_started) begin
            m_terr  = 1'b0;
            m_acked = -1;
            m_elig  = (msix_enable && !func_mask) ? (m_pending & ~vec_mask) : '0;
            if (m_out < 0) begin
                m_found = 1'b0;
                for (int k = 1; k <= NV; k++) begin
                    if (!m_found && m_elig[(m_last + k) % NV]) begin
                        m_found      = 1'b1;
                        m_out        = (m_last + k) % NV;
                        m_vec        = 11'(m_out);
                        m_wait_start = cyc + 2;
                        exp_vec_q.push_back(m_out);
                        exp_cyc_q.push_back(cyc + 1);
                    end
                end
            end else if (cyc >= m_wait_start) begin
                if (ack) begin
                    m_acked = m_out;
                    m_last  = m_out;
                    m_out   = -1;
                end else if (TO_EN && cyc == m_wait_start + TO - 1) begin
                    m_terr = 1'b1;
                    m_out  = -1;
                end
            end
            if (m_acked >= 0) m_pending[m_acked] = 1'b0;
            m_pending = m_pending | irq_req;
        end
        cyc++;
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (m_started) begin
            if (msix_interrupt === 1'b1) begin
                if (exp_vec_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL irq_unexpected: vector %0d at cycle %0d, none expected", msix_vector, cyc);
                end else begin
                    check("irq_vector", 32'(msix_vector), 32'(exp_vec_q.pop_front()));
                    check("irq_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end else if (exp_cyc_q.size() != 0 && exp_cyc_q[0] <= cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL irq_missing: no interrupt at cycle %0d, expected vector %0d", cyc, exp_vec_q[0]);
                void'(exp_vec_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            check("pending", 32'(pending), 32'(m_pending));
            check("busy", 32'(busy), 32'(m_out >= 0));
            check("timeout_err", 32'(timeout_err), 32'(m_terr));
            check("msix_vector_hold", 32'(msix_vector), 32'(m_vec));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_irq(input logic [NV-1:0] v);
        irq_req = v;
        tick(1);
        irq_req = '0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset       = 1'b1;
        irq_req     = '0;
        vec_mask    = '0;
        msix_enable = 1'b0;
        func_mask   = 1'b0;
        ack         = 1'b0;
        tick(3);
        reset = 1'b0;
        check("reset_pending", 32'(pending), 32'h0);
        check("reset_interrupt", 32'(msix_interrupt), 32'h0);
        check("reset_vector", 32'(msix_vector), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        msix_enable = 1'b1;
        tick(2);

        // Single event on vector 3: pending at N+1, request at N+2, ack at N+5.
        pulse_irq(NV'(8));                       // now in N+1
        check("s1_pending_n1", 32'(pending), 32'h08);
        tick(1);                                 // N+2
        check("s1_irq_n2", 32'(msix_interrupt), 32'h1);
        check("s1_vec_n2", 32'(msix_vector), 32'h3);
        tick(3);                                 // N+5
        ack = 1'b1;
        tick(1);                                 // N+6
        ack = 1'b0;
        check("s1_pending3_clr", 32'(pending[3]), 32'h0);
        tick(3);

        // Two events, immediate acks: order 0, 2 then again 0, 2.
        ack = 1'b1;
        pulse_irq(NV'(5));
        tick(10);
        pulse_irq(NV'(5));
        tick(10);
        ack = 1'b0;
        tick(2);

        // Masked vector stays pending until the mask is released.
        vec_mask = NV'(2);
        pulse_irq(NV'(2));
        tick(4);
        check("s3_masked_pending", 32'(pending), 32'h02);
        check("s3_masked_idle", 32'(busy), 32'h0);
        vec_mask = '0;
        ack = 1'b1;
        tick(6);
        ack = 1'b0;
        tick(2);

        // No ack: with the timeout build the vector is retried after a pulse.
        pulse_irq(NV'(32));
        tick(16);
        ack = 1'b1;
        tick(6);
        ack = 1'b0;
        tick(2);

        // Event on vector 0 coincident with its ack keeps it pending.
        pulse_irq(NV'(1));                       // N+1
        tick(2);                                 // N+3, first WAIT_ACK cycle
        ack     = 1'b1;
        irq_req = NV'(1);
        tick(1);
        ack     = 1'b0;
        irq_req = '0;
        check("s5_pending0_kept", 32'(pending[0]), 32'h1);
        tick(3);
        ack = 1'b1;
        tick(4);
        ack = 1'b0;
        tick(2);

        // Reset in WAIT_ACK discards the request; a later ack is ignored.
        pulse_irq(NV'(64));
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("s6_rst_pending", 32'(pending), 32'h0);
        check("s6_rst_busy", 32'(busy), 32'h0);
        check("s6_rst_interrupt", 32'(msix_interrupt), 32'h0);
        check("s6_rst_vector", 32'(msix_vector), 32'h0);
        check("s6_rst_timeout", 32'(timeout_err), 32'h0);
        ack = 1'b1;
        tick(2);
        ack = 1'b0;
        check("s6_ack_ignored", 32'(busy), 32'h0);
        tick(2);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            irq_req     = ($urandom_range(0, 3) == 0) ? NV'($urandom_range(0, 255)) : '0;
            if ($urandom_range(0, 19) == 0) vec_mask = NV'($urandom_range(0, 255) & $urandom_range(0, 255));
            msix_enable = ($urandom_range(0, 15) != 0);
            func_mask   = ($urandom_range(0, 15) == 0);
            ack         = ($urandom_range(0, 2) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            tick(1);
        end

        // Drain everything still pending.
        reset       = 1'b0;
        irq_req     = '0;
        vec_mask    = '0;
        msix_enable = 1'b1;
        func_mask   = 1'b0;
        ack         = 1'b1;
        tick(60);
        check("drain_pending", 32'(pending), 32'h0);
        check("exp_queue_empty", 32'(exp_vec_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
